// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - burst reader draining a synchronous FIFO into a ready/valid stream
//
// Reads burst_len words from a synchronous FIFO (one-cycle read latency) and
// presents them in order on a ready/valid output through a 2-entry buffer.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, burst_len  burst request (accepted in IDLE only) and word count
//   fifo_empty        FIFO empty flag
//   fifo_rd_en        FIFO read strobe
//   fifo_dout         FIFO read data, valid the cycle after fifo_rd_en
//   m_valid, m_ready  output handshake
//   m_data            oldest buffered word
//   busy              high while reading or draining
//   done              one-cycle pulse at burst completion
//   rd_count          words handed downstream in the current/last burst
module fifo_reader #(
  parameter int DATA = 8,
  parameter int ADDR = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ADDR:0]   burst_len,
  input  logic            fifo_empty,
  output logic            fifo_rd_en,
  input  logic [DATA-1:0] fifo_dout,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DATA-1:0] m_data,
  output logic            busy,
  output logic            done,
  output logic [ADDR:0]   rd_count
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [ADDR:0]   r_len;
  logic [ADDR:0]   r_issued;
  logic [ADDR:0]   r_rd_count;
  logic [DATA-1:0] r_buf0;      // oldest word
  logic [DATA-1:0] r_buf1;
  logic [1:0]      r_occ;
  logic            r_inflight;  // a read was issued last cycle; its data is on fifo_dout now
  logic            w_pop;
  logic            w_rd_en;
  logic [2:0]      w_level;

  assign w_pop   = (r_occ != 2'd0) && m_ready;
  // Words already committed to the buffer: held now plus the one arriving this edge.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight};

  always_comb begin
    w_rd_en = 1'b0;
    if ((r_state == S_READ) && !fifo_empty && (r_issued < r_len) &&
        ((w_level - {2'b00, w_pop}) < 3'd2)) begin
      w_rd_en = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (burst_len != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        if (r_issued == r_len) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as soon as the buffer empties on this edge so done follows the
        // last handshake by one cycle.
        if (!r_inflight && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop))) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len      <= '0;
      r_issued   <= '0;
      r_rd_count <= '0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_issued <= r_issued + 1'b1;
      end
      if ((r_state == S_IDLE) && start) begin
        r_rd_count <= '0;
        r_issued   <= '0;
        if (burst_len != '0) begin
          r_len <= burst_len;
        end
      end else if (w_pop && (r_rd_count < r_len)) begin
        r_rd_count <= r_rd_count + 1'b1;
      end
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_buf0 <= fifo_dout;
          end else begin
            r_buf1 <= fifo_dout;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          // Write and pop together: occupancy unchanged, shift then append.
          if (r_occ == 2'd1) begin
            r_buf0 <= fifo_dout;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo_dout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign m_valid    = (r_occ != 2'd0);
  assign m_data     = r_buf0;
  assign busy       = (r_state == S_READ) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign rd_count   = r_rd_count;

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - self-checking bench for fifo_reader
module tb_fifo_reader;
  localparam int DATA = 8;
  localparam int ADDR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [ADDR:0]   burst_len;
  logic            fifo_empty;
  logic            fifo_rd_en;
  logic [DATA-1:0] fifo_dout = '0;
  logic            m_valid;
  logic            m_ready;
  logic [DATA-1:0] m_data;
  logic            busy;
  logic            done;
  logic [ADDR:0]   rd_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA-1:0] fmem [0:1023];
  int   wr_idx = 0;
  int   rd_idx = 0;
  logic force_empty = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  fifo_reader #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .done(done), .rd_count(rd_count)
  );

  // Synchronous FIFO model: one-cycle read latency.
  assign fifo_empty = force_empty || (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (flush) begin
      rd_idx <= wr_idx;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= fmem[rd_idx];
      rd_idx    <= rd_idx + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [DATA-1:0] v);
    fmem[wr_idx] = v;
    wr_idx++;
  endtask

  // Entered just after a rising edge. mode: 0 ready=1, 1 random ready/empty,
  // 2 ready low for 10 cycles, 3 FIFO forced empty for 4 cycles mid-burst.
  task automatic run_burst(input int len, input int mode);
    int base, n_rd, n_hs, n_done, first_rd, done_cyc, last_hs, stall_rd;
    int inbuf, pop, t;
    bit rd_prev, seen_valid, prev_stall, finished, exp_rd;
    logic [DATA-1:0] prev_data;
    base = rd_idx;
    n_rd = 0; n_hs = 0; n_done = 0; first_rd = -1; done_cyc = -1; last_hs = -1;
    stall_rd = 0; rd_prev = 0; seen_valid = 0; prev_stall = 0; finished = 0;
    prev_data = '0;
    for (t = 0; t < 400 && !finished; t++) begin
      start = (t == 0);
      burst_len = len[ADDR:0];
      case (mode)
        1: begin m_ready = ($urandom % 4) != 0; force_empty = ($urandom % 5) == 0; end
        2: begin m_ready = !(t >= 4 && t < 14); force_empty = 1'b0; end
        3: begin m_ready = 1'b1; force_empty = (t >= 3 && t < 7); end
        default: begin m_ready = 1'b1; force_empty = 1'b0; end
      endcase
      @(negedge clk);
      inbuf = n_rd - int'(rd_prev) - n_hs;
      pop = (m_ready && inbuf > 0) ? 1 : 0;
      exp_rd = (t > 0) && (n_rd < len) && !fifo_empty && ((n_rd - n_hs - pop) < 2);
      check("m_valid", m_valid, inbuf > 0);
      check("fifo_rd_en", fifo_rd_en, exp_rd);
      if (t > 0 && n_hs < len) check("busy", busy, 1);
      if (prev_stall) check("hold_data", m_data, prev_data);
      if (fifo_rd_en) begin
        if (first_rd < 0) first_rd = t;
        n_rd++;
        if (mode == 2 && !m_ready) stall_rd++;
      end
      if (m_valid && !seen_valid) begin
        seen_valid = 1;
        check("first_latency", t - first_rd, 2);
      end
      if (m_valid && m_ready) begin
        check("m_data", m_data, fmem[base + n_hs]);
        n_hs++;
        last_hs = t;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = t;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      rd_prev    = fifo_rd_en;
      if (done_cyc >= 0 && t >= done_cyc + 2) finished = 1;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    force_empty = 1'b0;
    check("timeout", finished, 1);
    check("done_pulses", n_done, 1);
    check("read_pulses", n_rd, len);
    check("words_out", n_hs, len);
    check("rd_count", rd_count, len);
    if (len == 0) check("done_cycle", done_cyc, 1);
    else check("done_cycle", done_cyc, last_hs + 1);
    if (mode == 2) check("stall_reads", stall_rd <= 2, 1);
  endtask

  initial begin
    int hs, len;
    logic [DATA-1:0] seq5 [0:4];
    seq5[0] = 8'h24; seq5[1] = 8'h81; seq5[2] = 8'h09; seq5[3] = 8'h63; seq5[4] = 8'h0D;
    rst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_count", rd_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) push_word(seq5[i]);
    run_burst(5, 0);

    for (int i = 0; i < 16; i++) push_word(8'($urandom));
    run_burst(16, 2);

    for (int i = 0; i < 10; i++) push_word(8'($urandom));
    run_burst(10, 3);

    run_burst(0, 0);

    // Reset in the middle of an 8-word burst.
    for (int i = 0; i < 8; i++) push_word(8'($urandom));
    start = 1'b1; burst_len = 5'd8; m_ready = 1'b1;
    hs = 0;
    for (int t = 0; t < 50 && hs < 3; t++) begin
      @(negedge clk);
      if (m_valid && m_ready) hs++;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("mid_reset_reached", hs, 3);
    rst = 1'b1;
    flush = 1'b1;
    #1;
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_rd_en", fifo_rd_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd_count", rd_count, 0);
    check("mid_rst_m_data", m_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush = 1'b0;
    push_word(8'hA5);
    push_word(8'h5A);
    run_burst(2, 0);

    for (int b = 0; b < 6; b++) begin
      len = $urandom_range(0, 16);
      for (int i = 0; i < len; i++) push_word(8'($urandom));
      run_burst(len, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA, default 8: word width in bits.
REQ-002 Parameter ADDR, default 4: FIFO address width; burst and count fields are ADDR+1 bits wide, so a full FIFO of DEPTH = 2**ADDR = 16 words can be drained in one burst.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  burst request; sampled in IDLE only.
REQ-006 burst_len  input  ADDR+1  number of words to read; sampled when start is accepted.
REQ-007 fifo_empty  input  1  empty flag from the attached synchronous FIFO.
REQ-008 fifo_rd_en  output  1  read strobe to the FIFO.
REQ-009 fifo_dout  input  DATA  FIFO read data; valid on the cycle after fifo_rd_en was high.
REQ-010 m_valid  output  1  output word valid.
REQ-011 m_ready  input  1  downstream accept.
REQ-012 m_data  output  DATA  output word.
REQ-013 busy  output  1  high in READ and DRAIN.
REQ-014 done  output  1  one-cycle pulse when a burst completes.
REQ-015 rd_count  output  ADDR+1  words handed over downstream in the current or last burst.

Function
REQ-016 The FSM SHALL have four states, IDLE, READ, DRAIN and DONE, with the transitions in REQ-017 to REQ-020.
REQ-017 In IDLE, start=1 with burst_len>0 SHALL latch burst_len, clear rd_count and go to READ; start=1 with burst_len=0 SHALL clear rd_count and go to DONE.
REQ-018 In READ, the FSM SHALL move to DRAIN in the cycle after the read-issue counter reaches the latched length.
REQ-019 In DRAIN, the FSM SHALL move to DONE when the output buffer is empty and no read is in flight.
REQ-020 In DONE, done SHALL be 1 for exactly that cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 fifo_rd_en SHALL be high only when all of the following hold: state=READ, fifo_empty=0, issued<length, and (buffer occupancy + in-flight reads - pop) < 2, where pop = m_valid & m_ready in the same cycle.
REQ-023 fifo_rd_en SHALL never be high while fifo_empty=1.
REQ-024 Each fifo_rd_en pulse SHALL mark one read in flight; fifo_dout SHALL be written into a 2-entry output buffer on the following edge.
REQ-025 m_valid SHALL be high whenever the output buffer is non-empty; m_data SHALL be the oldest buffered word.
REQ-026 The first m_valid SHALL appear 2 cycles after the first fifo_rd_en (no combinational bypass).
REQ-027 Words SHALL leave the block in exactly the order they were read from the FIFO.
REQ-028 While m_valid=1 and m_ready=0, m_data SHALL stay stable and m_valid SHALL stay high.
REQ-029 With m_ready held at 1 and the FIFO non-empty, the block SHALL issue one read per cycle (full throughput).
REQ-030 A simultaneous buffer write and pop SHALL leave occupancy unchanged; occupancy SHALL never exceed 2.
REQ-031 rd_count SHALL increment on each m_valid & m_ready; it SHALL saturate at the latched length and hold its value in IDLE until the next accepted start.
REQ-032 The issue counter and rd_count SHALL be ADDR+1 bits wide and SHALL not wrap within a burst.

Reset
REQ-033 While rst=1: state=IDLE, fifo_rd_en=0, m_valid=0, m_data=0, busy=0, done=0, rd_count=0, occupancy=0, in-flight=0.
REQ-034 Reset asserted mid-burst SHALL discard buffered and in-flight words immediately; a late fifo_dout arriving after reset SHALL NOT be captured.
REQ-035 After rst deasserts, the first start SHALL be accepted on the first rising edge on which rst=0.

Verification
REQ-036 Reset check: assert rst with the block idle -> every output is 0 and the state is IDLE.
REQ-037 Full-throughput burst: FIFO preloaded with 8'h24,8'h81,8'h09,8'h63,8'h0D; burst_len=5; m_ready=1 -> fifo_rd_en high for 5 consecutive cycles; m_data is 24,81,09,63,0D in order; rd_count=5; done pulses once, one cycle after the last handshake.
REQ-038 Backpressure: m_ready=0 for 10 cycles during a 16-word burst -> at most 2 fifo_rd_en pulses; m_data is held; after release all 16 words arrive in order with none lost or duplicated.
REQ-039 Underflow guard: fifo_empty=1 for 4 cycles mid-burst -> fifo_rd_en stays 0 and busy stays 1; reading resumes the cycle after fifo_empty=0.
REQ-040 Zero length: start with burst_len=0 -> no fifo_rd_en; done=1 in the cycle after start; rd_count=0.
REQ-041 Reset mid-burst: rst pulsed after 3 of 8 words -> m_valid=0 immediately; a new 2-word burst afterwards delivers only the new words.
